flp_adder_norm_stage: RTL and testbench

//   Final stage of the floating-point adder pipeline, at the opposite end from the exponent-compare/align first stage.
//   - Input: result sign, the larger (common) exponent and the raw aligned mantissa sum.
//   - Work: renormalises iteratively, one shift per cycle; applies overflow/underflow rules.
//   - Output: a packed bfloat16-style result through a valid/ready handshake. One transaction in flight at a time.

---
 rtl/flp_adder_norm_stage.sv | 219 +++++++++++++++++++++
 tb/tb_flp_adder_norm_stage.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/flp_adder_norm_stage.sv
// flp_adder_norm_stage: last stage of the floating-point adder pipeline.
// Takes the result sign, the common exponent and the aligned mantissa sum,
// renormalises one shift per cycle, applies overflow/underflow rules and
// returns a packed bfloat16-style result over a valid/ready handshake.
// Optional feature macro: FLP_NORM_ROUND_EN (round-to-nearest-even instead
// of truncation when the hidden bit is reached).
module flp_adder_norm_stage #(
    parameter int EXP_W  = 8,
    parameter int MANT_W = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic [MANT_W+2:0] in_sum,
    input  logic              in_sticky,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sign,
    output logic [EXP_W-1:0]  out_exp,
    output logic [MANT_W-1:0] out_mant,
    output logic              out_ovf,
    output logic              out_unf
);

    localparam int SUM_W = MANT_W + 3;   // {carry, hidden, fraction, guard}

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_NORM = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [EXP_W-1:0] EXP_ONES = '1;
    localparam logic [EXP_W-1:0] EXP_ONE  = EXP_W'(1);

    logic [1:0]        state_q,    state_d;
    logic              sign_q,     sign_d;
    logic [EXP_W-1:0]  exp_q,      exp_d;
    logic [SUM_W-1:0]  sum_q,      sum_d;
    logic              valid_q,    valid_d;
    logic [EXP_W-1:0]  res_exp_q,  res_exp_d;
    logic [MANT_W-1:0] res_mant_q, res_mant_d;
    logic              ovf_q,      ovf_d;
    logic              unf_q,      unf_d;

    // Exponent increment carried one bit wider so the wrap past all-ones is visible.
    logic [EXP_W:0]    exp_inc;
    logic              exp_inc_ovf;

`ifdef FLP_NORM_ROUND_EN
    logic              sticky_q, sticky_d;
    logic              round_up;
    logic [MANT_W:0]   frac_rnd;
`else
    // Truncation ignores the sticky input entirely.
    logic              unused_sticky;
    assign unused_sticky = in_sticky;
`endif

    assign exp_inc     = {1'b0, exp_q} + {{EXP_W{1'b0}}, 1'b1};
    assign exp_inc_ovf = exp_inc[EXP_W] || (exp_inc[EXP_W-1:0] == EXP_ONES);

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = valid_q;
    assign out_sign  = sign_q;
    assign out_exp   = res_exp_q;
    assign out_mant  = res_mant_q;
    assign out_ovf   = ovf_q;
    assign out_unf   = unf_q;

    // Next-state and datapath: one normalisation action per NORM cycle.
    always_comb begin
        // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
        state_d    = state_q;
        sign_d     = sign_q;
        exp_d      = exp_q;
        sum_d      = sum_q;
        valid_d    = valid_q;
        res_exp_d  = res_exp_q;
        res_mant_d = res_mant_q;
        ovf_d      = ovf_q;
        unf_d      = unf_q;
`ifdef FLP_NORM_ROUND_EN
        sticky_d   = sticky_q;
        round_up   = sum_q[0] & (sticky_q | sum_q[1]);
        frac_rnd   = {1'b0, sum_q[MANT_W:1]} + {{MANT_W{1'b0}}, round_up};
`endif

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    sign_d     = in_sign;
                    exp_d      = in_exp;
                    sum_d      = in_sum;
`ifdef FLP_NORM_ROUND_EN
                    sticky_d   = in_sticky;
`endif
                    res_exp_d  = '0;
                    res_mant_d = '0;
                    ovf_d      = 1'b0;
                    unf_d      = 1'b0;
                    state_d    = ST_NORM;
                end
            end

            ST_NORM: begin
                if (sum_q == '0) begin
                    // Exact zero: sign is kept, no flag.
                    res_exp_d  = '0;
                    res_mant_d = '0;
                    state_d    = ST_DONE;
                end else if (exp_q == '0) begin
                    res_exp_d  = '0;
                    res_mant_d = '0;
                    unf_d      = 1'b1;
                    state_d    = ST_DONE;
                end else if (exp_q == EXP_ONES) begin
                    // Exponent already saturated on entry: result is infinity.
                    res_exp_d  = EXP_ONES;
                    res_mant_d = '0;
                    ovf_d      = 1'b1;
                    state_d    = ST_DONE;
                end else if (sum_q[SUM_W-1]) begin
                    // Carry out of the add: shift right, fold guard into sticky.
                    sum_d = {1'b0, sum_q[SUM_W-1:1]};
                    exp_d = exp_inc[EXP_W-1:0];
`ifdef FLP_NORM_ROUND_EN
                    sticky_d = sticky_q | sum_q[0];
`endif
                    if (exp_inc_ovf) begin
                        res_exp_d  = EXP_ONES;
                        res_mant_d = '0;
                        ovf_d      = 1'b1;
                        state_d    = ST_DONE;
                    end
                end else if (sum_q[SUM_W-2]) begin
                    // Normalised: emit the fraction.
`ifdef FLP_NORM_ROUND_EN
                    if (frac_rnd[MANT_W]) begin
                        res_mant_d = '0;
                        if (exp_inc_ovf) begin
                            res_exp_d = EXP_ONES;
                            ovf_d     = 1'b1;
                        end else begin
                            res_exp_d = exp_inc[EXP_W-1:0];
                        end
                    end else begin
                        res_exp_d  = exp_q;
                        res_mant_d = frac_rnd[MANT_W-1:0];
                    end
`else
                    res_exp_d  = exp_q;
                    res_mant_d = sum_q[MANT_W:1];
`endif
                    state_d = ST_DONE;
                end else if (exp_q == EXP_ONE) begin
                    // Would need a denormal: flush to zero instead.
                    res_exp_d  = '0;
                    res_mant_d = '0;
                    unf_d      = 1'b1;
                    state_d    = ST_DONE;
                end else begin
                    // Leading zero: shift left, guard moves into the fraction LSB.
                    sum_d = {sum_q[SUM_W-2:0], 1'b0};
                    exp_d = exp_q - EXP_ONE;
                end
            end

            ST_DONE: begin
                // out_valid rises the cycle after entering DONE and holds until taken.
                if (valid_q && out_ready) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    valid_d = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // State registers with synchronous active-low reset; reset drops any transaction in flight.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            sign_q     <= 1'b0;
            exp_q      <= '0;
            sum_q      <= '0;
            valid_q    <= 1'b0;
            res_exp_q  <= '0;
            res_mant_q <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
`ifdef FLP_NORM_ROUND_EN
            sticky_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            sign_q     <= sign_d;
            exp_q      <= exp_d;
            sum_q      <= sum_d;
            valid_q    <= valid_d;
            res_exp_q  <= res_exp_d;
            res_mant_q <= res_mant_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
`ifdef FLP_NORM_ROUND_EN
            sticky_q   <= sticky_d;
`endif
        end
    end

endmodule

// File: tb/tb_flp_adder_norm_stage.sv
// Directed bench for flp_adder_norm_stage (EXP_W=8, MANT_W=7).
// Expected values are hand-computed; rounding cases switch on FLP_NORM_ROUND_EN.
module tb_flp_adder_norm_stage;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic       in_sign;
    logic [7:0] in_exp;
    logic [9:0] in_sum;
    logic       in_sticky;
    logic       out_valid;
    logic       out_ready;
    logic       out_sign;
    logic [7:0] out_exp;
    logic [6:0] out_mant;
    logic       out_ovf;
    logic       out_unf;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    flp_adder_norm_stage #(.EXP_W(8), .MANT_W(7)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_exp(in_exp), .in_sum(in_sum), .in_sticky(in_sticky),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sign(out_sign), .out_exp(out_exp), .out_mant(out_mant),
        .out_ovf(out_ovf), .out_unf(out_unf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Present one transaction at a negedge; the following posedge is the accept edge.
    task automatic start_txn(input string tag, input logic s, input logic [7:0] e,
                             input logic [9:0] m, input logic st);
        @(negedge clk);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        in_sign   = s;
        in_exp    = e;
        in_sum    = m;
        in_sticky = st;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Count edges after the accept edge until out_valid; bounded. lat<0 skips the latency check.
    task automatic wait_valid(input string tag, input int lat);
        int cycles = 0;
        do begin
            if (cycles > 0 || 1'b1) begin
                @(posedge clk);
                cycles++;
                #1;
            end
        end while (!out_valid && cycles < 20);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        if (lat >= 0) check({tag, "_latency"}, 32'(cycles), 32'(lat));
    endtask

    task automatic check_res(input string tag, input logic s, input logic [7:0] e,
                             input logic [6:0] m, input logic ovf, input logic unf);
        check({tag, "_sign"}, 32'(out_sign), 32'(s));
        check({tag, "_exp"},  32'(out_exp),  32'(e));
        check({tag, "_mant"}, 32'(out_mant), 32'(m));
        check({tag, "_ovf"},  32'(out_ovf),  32'(ovf));
        check({tag, "_unf"},  32'(out_unf),  32'(unf));
    endtask

    task automatic release_out(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_drop_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_back_idle"},  32'(in_ready),  32'd1);
        out_ready = 1'b0;
    endtask

    task automatic run(input string tag, input logic s, input logic [7:0] e, input logic [9:0] m,
                       input logic st, input int lat, input logic [7:0] xe, input logic [6:0] xm,
                       input logic xo, input logic xu);
        start_txn(tag, s, e, m, st);
        wait_valid(tag, lat);
        check_res(tag, s, xe, xm, xo, xu);
        release_out(tag);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_sign = 1'b0; in_exp = '0; in_sum = '0; in_sticky = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check_res("rst", 1'b0, 8'd0, 7'd0, 1'b0, 1'b0);
        @(negedge clk) rst_n = 1'b1;

        // 1.0 + 1.0: one right shift
        run("one_plus_one", 1'b0, 8'd127, 10'h200, 1'b0, 3, 8'd128, 7'h00, 1'b0, 1'b0);
        // Cancellation: six left shifts
        run("cancel", 1'b0, 8'd127, 10'h004, 1'b0, 8, 8'd121, 7'h00, 1'b0, 1'b0);
        // Zero sum keeps sign, no flag
        run("zero", 1'b1, 8'd100, 10'h000, 1'b0, 2, 8'd0, 7'h00, 1'b0, 1'b0);
        // Overflow on the carry shift
        run("ovf", 1'b0, 8'd254, 10'h200, 1'b0, -1, 8'd255, 7'h00, 1'b1, 1'b0);
        // Underflow after two shifts
        run("unf", 1'b0, 8'd3, 10'h020, 1'b0, 4, 8'd0, 7'h00, 1'b0, 1'b1);
        // Input exponent already all-ones
        run("exp_ones", 1'b1, 8'd255, 10'h100, 1'b0, -1, 8'd255, 7'h00, 1'b1, 1'b0);
        // Input exponent zero with nonzero sum
        run("exp_zero", 1'b0, 8'd0, 10'h100, 1'b0, 2, 8'd0, 7'h00, 1'b0, 1'b1);
        // Already normalised, fraction passes through
        run("normal", 1'b1, 8'd130, 10'h1AA, 1'b0, 2, 8'd130, 7'h55, 1'b0, 1'b0);
        // One left shift: guard enters the fraction LSB
        run("guard_in", 1'b0, 8'd10, 10'h0FF, 1'b0, 3, 8'd9, 7'h7F, 1'b0, 1'b0);
        // Tie with even LSB: no round-up either way
        run("tie_even", 1'b0, 8'd50, 10'h1A9, 1'b0, 2, 8'd50, 7'h54, 1'b0, 1'b0);
`ifdef FLP_NORM_ROUND_EN
        run("round_1ff",  1'b0, 8'd127, 10'h1FF, 1'b0, 2, 8'd128, 7'h00, 1'b0, 1'b0);
        run("carry_rnd",  1'b0, 8'd100, 10'h3FE, 1'b0, 3, 8'd102, 7'h00, 1'b0, 1'b0);
        run("sticky_rnd", 1'b0, 8'd50,  10'h1A9, 1'b1, 2, 8'd50,  7'h55, 1'b0, 1'b0);
        run("rnd_ovf",    1'b0, 8'd254, 10'h1FF, 1'b0, 2, 8'd255, 7'h00, 1'b1, 1'b0);
`else
        run("round_1ff",  1'b0, 8'd127, 10'h1FF, 1'b0, 2, 8'd127, 7'h7F, 1'b0, 1'b0);
        run("carry_rnd",  1'b0, 8'd100, 10'h3FE, 1'b0, 3, 8'd101, 7'h7F, 1'b0, 1'b0);
        run("sticky_rnd", 1'b0, 8'd50,  10'h1A9, 1'b1, 2, 8'd50,  7'h54, 1'b0, 1'b0);
        run("rnd_ovf",    1'b0, 8'd254, 10'h1FF, 1'b0, 2, 8'd254, 7'h7F, 1'b0, 1'b0);
`endif

        // Backpressure: result held, second request ignored
        start_txn("bp", 1'b1, 8'd127, 10'h200, 1'b0);
        wait_valid("bp", 3);
        @(negedge clk);
        in_valid = 1'b1; in_sign = 1'b0; in_exp = 8'd5; in_sum = 10'h004;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_ready", 32'(in_ready),  32'd0);
            check_res("bp_hold", 1'b1, 8'd128, 7'h00, 1'b0, 1'b0);
        end
        in_valid = 1'b0;
        release_out("bp");
        repeat (3) @(posedge clk);
        #1;
        check("bp_no_second", 32'(out_valid), 32'd0);
        check("bp_idle",      32'(in_ready),  32'd1);

        // Reset during NORM discards the transaction
        start_txn("midrst", 1'b1, 8'd127, 10'h004, 1'b0);
        @(posedge clk);
        @(negedge clk) rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_ready", 32'(in_ready),  32'd1);
        check("midrst_valid", 32'(out_valid), 32'd0);
        check_res("midrst", 1'b0, 8'd0, 7'd0, 1'b0, 1'b0);
        @(negedge clk) rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("midrst_stays_idle",  32'(out_valid), 32'd0);
        check("midrst_stays_ready", 32'(in_ready),  32'd1);

        // Fresh transaction after reset still works
        run("post_rst", 1'b0, 8'd127, 10'h200, 1'b0, 3, 8'd128, 7'h00, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
